// File: rtl/ddr_handshake_tx_ctrl_pkg.sv
// Shared types and constants for the REQ/ACK source-side handshake controller.
// Imported by the interface, the ACK synchronizer and the controller top.
package ddr_handshake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_REQ_HI = 2'd2,
    ST_REQ_LO = 2'd3
  } hs_state_e;

  localparam int XFER_COUNT_W    = 16;
  localparam int DEF_DATA_WIDTH  = 24;
  localparam int DEF_SYNC_STAGES = 4;

endpackage

// File: rtl/ddr_handshake_tx_ctrl_if.sv
// Word-input, far-domain request/acknowledge and status bundle of the controller.
// master = controller side, slave = producer / far-domain side.
interface ddr_handshake_tx_ctrl_if
  import ddr_handshake_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0]   DIN;
  logic                    DIN_VALID;
  logic                    DIN_READY;
  logic [DATA_WIDTH-1:0]   XFER_DATA;
  logic                    XFER_REQ;
  logic                    XFER_ACK_ASYNC;
  logic                    BUSY;
  logic [XFER_COUNT_W-1:0] XFER_COUNT;
  logic                    ERR_CLR;
  logic                    TIMEOUT;
  logic                    ERR;

  modport master (
    input  DIN, DIN_VALID, XFER_ACK_ASYNC, ERR_CLR,
    output DIN_READY, XFER_DATA, XFER_REQ, BUSY, XFER_COUNT, TIMEOUT, ERR
  );

  modport slave (
    output DIN, DIN_VALID, XFER_ACK_ASYNC, ERR_CLR,
    input  DIN_READY, XFER_DATA, XFER_REQ, BUSY, XFER_COUNT, TIMEOUT, ERR
  );

endinterface

// File: rtl/ddr_handshake_tx_ctrl_ack_sync.sv
// Multi-stage synchronizer bringing the far-domain ACK into CLK, plus a primed
// flag that rises once the chain has been refilled after reset.
module ddr_handshake_ack_sync
  import ddr_handshake_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic ack_async,
  output logic ack_sync,
  output logic primed
);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] prime_r;

  // sync_r is only trustworthy once prime_r has shifted a 1 through the same depth
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_r  <= '0;
      prime_r <= '0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], ack_async};
      prime_r <= {prime_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ack_sync = sync_r[SYNC_STAGES-1];
  assign primed   = prime_r[SYNC_STAGES-1];

endmodule

// File: rtl/ddr_handshake_tx_ctrl.sv
// Four-phase REQ/ACK source controller driving a held word into another clock domain.
// Optional per-phase abort enabled by defining HANDSHAKE_TIMEOUT_EN.
module ddr_handshake_tx_ctrl
  import ddr_handshake_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                     CLK,
  input logic                     RST_N,
  ddr_handshake_tx_ctrl_if.master bus
);

  hs_state_e               state_r;
  hs_state_e               state_nxt_s;
  logic                    ack_s;
  logic                    primed_s;
  logic                    phase_expired_s;
  logic                    accept_s;
  logic                    req_set_s;
  logic                    req_clr_s;
  logic                    count_inc_s;
  logic                    timeout_hit_s;
  logic                    ready_nxt_s;
  logic [DATA_WIDTH-1:0]   xfer_data_r;
  logic                    xfer_req_r;
  logic                    din_ready_r;
  logic [XFER_COUNT_W-1:0] xfer_count_r;
  logic                    timeout_r;
  logic                    err_r;

  ddr_handshake_ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ack_async (bus.XFER_ACK_ASYNC),
    .ack_sync  (ack_s),
    .primed    (primed_s)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // On an ACK arriving in the same cycle as expiry, the normal completion wins.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.DIN_VALID && din_ready_r) state_nxt_s = ST_SETUP;
        else                              state_nxt_s = ST_IDLE;
      end
      ST_SETUP: state_nxt_s = ST_REQ_HI;
      ST_REQ_HI: begin
        if (ack_s || phase_expired_s) state_nxt_s = ST_REQ_LO;
        else                          state_nxt_s = ST_REQ_HI;
      end
      ST_REQ_LO: begin
        if (!ack_s || phase_expired_s) state_nxt_s = ST_IDLE;
        else                           state_nxt_s = ST_REQ_LO;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_s      = 1'b0;
    req_set_s     = 1'b0;
    req_clr_s     = 1'b0;
    count_inc_s   = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE:  accept_s  = bus.DIN_VALID && din_ready_r;
      ST_SETUP: req_set_s = 1'b1;
      ST_REQ_HI: begin
        req_clr_s     = ack_s || phase_expired_s;
        count_inc_s   = ack_s;
        timeout_hit_s = !ack_s && phase_expired_s;
      end
      ST_REQ_LO: timeout_hit_s = ack_s && phase_expired_s;
      default:   accept_s = 1'b0;
    endcase
    // Held low until the synchronizer has refilled, so a stuck-high ACK is never missed.
    ready_nxt_s = (state_nxt_s == ST_IDLE) && primed_s && !ack_s;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      xfer_data_r  <= '0;
      xfer_req_r   <= 1'b0;
      xfer_count_r <= '0;
      din_ready_r  <= 1'b0;
    end else begin
      if (accept_s) xfer_data_r <= bus.DIN;
      else          xfer_data_r <= xfer_data_r;
      if (req_set_s)      xfer_req_r <= 1'b1;
      else if (req_clr_s) xfer_req_r <= 1'b0;
      else                xfer_req_r <= xfer_req_r;
      if (count_inc_s) xfer_count_r <= xfer_count_r + XFER_COUNT_W'(1);
      else             xfer_count_r <= xfer_count_r;
      din_ready_r <= ready_nxt_s;
    end
  end

`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int                 PHASE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(TIMEOUT_CYCLES - 1);

  logic [PHASE_W-1:0] phase_cnt_r;

  // Restarts on every state change, so each wait phase gets its own budget.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      phase_cnt_r <= '0;
    end else if (state_nxt_s != state_r) begin
      phase_cnt_r <= '0;
    end else if ((state_r == ST_REQ_HI) || (state_r == ST_REQ_LO)) begin
      phase_cnt_r <= phase_cnt_r + PHASE_W'(1);
    end else begin
      phase_cnt_r <= phase_cnt_r;
    end
  end

  assign phase_expired_s = ((state_r == ST_REQ_HI) || (state_r == ST_REQ_LO)) &&
                           (phase_cnt_r == PHASE_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      timeout_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      timeout_r <= timeout_hit_s;
      if (timeout_hit_s)    err_r <= 1'b1;
      else if (bus.ERR_CLR) err_r <= 1'b0;
      else                  err_r <= err_r;
    end
  end
`else
  logic [31:0] unused_cfg_s;

  assign phase_expired_s = 1'b0;
  assign timeout_r       = 1'b0;
  assign err_r           = 1'b0;
  assign unused_cfg_s    = 32'(TIMEOUT_CYCLES) ^ {31'd0, bus.ERR_CLR ^ timeout_hit_s};
`endif

  assign bus.DIN_READY  = din_ready_r;
  assign bus.XFER_DATA  = xfer_data_r;
  assign bus.XFER_REQ   = xfer_req_r;
  assign bus.BUSY       = (state_r != ST_IDLE);
  assign bus.XFER_COUNT = xfer_count_r;
  assign bus.TIMEOUT    = timeout_r;
  assign bus.ERR        = err_r;

endmodule

// File: doc/ddr_handshake_tx_ctrl.md
# ddr_handshake_tx_ctrl

Source-side controller for a four-phase REQ/ACK handshake that carries a multi-bit word into another clock domain. It accepts words on a valid/ready port and holds each one stable on XFER_DATA. It raises XFER_REQ and waits for the far side's ACK, brought into CLK through an internal multi-stage synchronizer. It then completes the return-to-zero phase. It sits in front of the 24-bit DDR crossing and is the only block allowed to drive its data bus and request line.

## Interface
- DATA_WIDTH, 24, width of the transferred word
- SYNC_STAGES, 4, flip-flop stages on the ACK synchronizer (legal: ≥3)
- TIMEOUT_CYCLES, 1023, per-phase abort limit in CLK cycles (only used with timeout enabled)
- CLK  in  1  sole clock
- RST_N  in  1  asynchronous, active-low reset
- DIN  in  DATA_WIDTH  word to transfer
- DIN_VALID  in  1  DIN is valid
- DIN_READY  out  1  controller can accept a word this cycle
- XFER_DATA  out  DATA_WIDTH  registered, stable word to far domain
- XFER_REQ  out  1  registered request to far domain
- XFER_ACK_ASYNC  in  1  acknowledge from far domain, asynchronous
- BUSY  out  1  state ≠ IDLE
- XFER_COUNT  out  16  completed transfers, wraps 0xFFFF→0x0000
- ERR_CLR  in  1  clears ERR
- TIMEOUT  out  1  one-cycle pulse on phase abort
- ERR  out  1  sticky timeout flag

## Operation
- ack_s: XFER_ACK_ASYNC after SYNC_STAGES registers.
- All outputs, synchronizer stages, state and counters reset asynchronously to 0. State resets to IDLE.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
- **IDLE**
  - DIN_READY = (ack_s == 0).
  - On DIN_VALID & DIN_READY: XFER_DATA <= DIN, then go to SETUP.
- **SETUP**
  - XFER_REQ <= 1, then go to REQ_HI.
  - Guarantees one full cycle of data setup before REQ rises.
- **REQ_HI**
  - Waits for ack_s == 1.
  - Then XFER_REQ <= 0, XFER_COUNT <= XFER_COUNT + 1, go to REQ_LO.
- **REQ_LO**
  - Waits for ack_s == 0, then goes to IDLE.
- XFER_DATA changes only on an accept in IDLE; it is held through SETUP, REQ_HI and REQ_LO.
- DIN_READY is 0 in all states other than IDLE.
- Reset mid-transfer: the bus returns to 0 immediately. If ACK is still high after reset, DIN_READY stays 0 until ack_s falls.
- ERR_CLR and a new timeout in the same cycle: the timeout wins and ERR stays 1.

## Timing
- Accept at edge k → XFER_DATA valid after k, XFER_REQ high after edge k+1.
- ACK rising after edge t is seen by the FSM at edge t+SYNC_STAGES+1.
- Loopback (ACK = REQ), SYNC_STAGES = 4:
  - REQ falls after k+6.
  - IDLE is reached at k+11.
  - Next accept at k+12.
- Minimum per-word period: 2·(SYNC_STAGES+1)+2 cycles.
- XFER_COUNT updates on the same edge that REQ falls.

## Configuration
- HANDSHAKE_TIMEOUT_EN defined:
  - A phase counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ_HI and on entry to REQ_LO.
  - The counter increments while the FSM waits in either state.
  - Reaching TIMEOUT_CYCLES in REQ_HI: XFER_REQ <= 0, go to REQ_LO, no count increment, TIMEOUT pulse, ERR <= 1.
  - Reaching TIMEOUT_CYCLES in REQ_LO: go to IDLE, TIMEOUT pulse, ERR <= 1.
- Undefined:
  - No counter is built.
  - TIMEOUT and ERR are tied 0; ERR_CLR is ignored.
  - The FSM waits indefinitely.
  - The port list is unchanged.

## Structure
- Shared package ddr_handshake_pkg:
  - FSM state enum (2-bit).
  - XFER_COUNT width constant (16).
  - Default DATA_WIDTH and SYNC_STAGES constants.
- Sub-module ddr_handshake_ack_sync:
  - SYNC_STAGES-deep ASYNC_REG synchronizer with shift-register extraction disabled.
  - Asynchronous active-low reset to 0.
  - Instantiated once, on XFER_ACK_ASYNC.

## Test plan
- Loopback ACK = REQ, SYNC_STAGES = 4, DIN = 0xA5A5A5 at edge k → XFER_DATA = 0xA5A5A5 after k, REQ high k+1..k+6, DIN_READY high after k+11, XFER_COUNT = 1.
- Back-to-back loopback, 3 words 0x000001/0x000002/0x000003 with DIN_VALID held high → accepts 12 cycles apart, XFER_DATA never changes while REQ = 1, XFER_COUNT = 3.
- XFER_COUNT preloaded via 0xFFFF transfers (or forced to 0xFFFF) plus one more transfer → XFER_COUNT = 0x0000.
- ACK held high at reset release → DIN_READY = 0; drop ACK → DIN_READY = 1 exactly SYNC_STAGES+1 cycles later.
- RST_N asserted while in REQ_HI → XFER_REQ, XFER_DATA, BUSY, XFER_COUNT = 0 with no clock edge; FSM = IDLE after release.
- HANDSHAKE_TIMEOUT_EN, TIMEOUT_CYCLES = 16, ACK tied 0 → REQ falls after 16 wait cycles, TIMEOUT pulses once, ERR = 1, XFER_COUNT unchanged; ERR_CLR → ERR = 0.
